ram_io_responder: RTL



---
 rtl/ram_io_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus memory-mapped TX/RX FIFO window answering the controller's memory bus
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_write,
    input  logic        is_write,
    output logic [7:0]  mem_result,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow
);
    localparam int TW = $clog2(TX_DEPTH);
    localparam int RW = $clog2(RX_DEPTH);
    localparam logic [TW:0] TX_MAX = (TW+1)'(TX_DEPTH);
    localparam logic [RW:0] RX_MAX = (RW+1)'(RX_DEPTH);

    logic [7:0]  ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0]  tx_mem [0:TX_DEPTH-1];
    logic [7:0]  rx_mem [0:RX_DEPTH-1];
    logic [TW-1:0] tx_rd, tx_wr;
    logic [RW-1:0] rx_rd, rx_wr;
    logic [TW:0] tx_count;
    logic [RW:0] rx_count;
    logic [ADDR_WIDTH-1:0] idx;
    logic io_sel, io_data, io_stat, rx_nonempty;
    logic ram_we, tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] rd_next;

    assign idx            = mem_a[ADDR_WIDTH-1:0];
    assign io_sel         = mem_a[31:16] == 16'h0003;
    assign io_data        = io_sel && mem_a[15:0] == 16'h0000;
    assign io_stat        = io_sel && mem_a[15:0] == 16'h0004;
    assign rx_nonempty    = rx_count != '0;
    assign io_buffer_full = tx_count == TX_MAX;
    assign tx_valid       = tx_count != '0;
    assign tx_data        = tx_mem[tx_rd];
    assign rx_ready       = rx_count != RX_MAX;
    assign ram_we         = rdy && is_write && !io_sel;
    assign tx_push        = rdy && is_write && io_data && !io_buffer_full;
    assign tx_pop         = rdy && tx_valid && tx_ready;
    assign rx_push        = rdy && rx_valid && rx_ready;
    assign rx_pop         = rdy && !is_write && io_data && rx_nonempty;

    // Read data mux: writes and unmapped I/O return zero
    always_comb begin
        rd_next = 8'h00;
        if (!is_write)
            rd_next = !io_sel ? ram[idx] :
                      io_data ? (rx_nonempty ? rx_mem[rx_rd] : 8'h00) :
                      io_stat ? {6'b0, rx_nonempty, io_buffer_full} : 8'h00;
    end

    // RAM array has no reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= mem_write;
    end

    // FIFO storage writes; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= mem_write;
        if (rx_push) rx_mem[rx_wr] <= rx_data;
    end

    // Pointers, counts, registered read result and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_rd       <= '0;
            tx_wr       <= '0;
            rx_rd       <= '0;
            rx_wr       <= '0;
            tx_count    <= '0;
            rx_count    <= '0;
            mem_result  <= 8'h00;
            tx_overflow <= 1'b0;
        end else if (rdy) begin
            mem_result <= rd_next;
            if (is_write && io_data && io_buffer_full) tx_overflow <= 1'b1;
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            tx_count <= tx_count + (TW+1)'(tx_push) - (TW+1)'(tx_pop);
            rx_count <= rx_count + (RW+1)'(rx_push) - (RW+1)'(rx_pop);
        end
    end
endmodule
